// File: rtl/dea_stream_cipher.sv
// Variable-length-key XOR stream cipher with valid handshake, key status and
// ciphertext-autokey mode (encrypt and matching decrypt).
module dea_stream_cipher #(
  parameter int DATA_W      = 8,
  parameter int MAX_KEY_LEN = 16,
  parameter int KL_W        = $clog2(MAX_KEY_LEN + 1)
) (
  input  logic              dclk,
  input  logic              reset,
  input  logic              kset,
  input  logic              mode,
  input  logic              decrypt,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [KL_W-1:0]   key_len,
  output logic              key_full,
  output logic              key_ovf
);

  localparam int              PTR_W  = (MAX_KEY_LEN > 1) ? $clog2(MAX_KEY_LEN) : 1;
  localparam logic [KL_W-1:0] KL_MAX = KL_W'(MAX_KEY_LEN);

  typedef enum logic {
    ST_CRYPT = 1'b0,
    ST_LOAD  = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_key [MAX_KEY_LEN];
  logic [PTR_W-1:0]  r_ptr;
  logic [KL_W-1:0]   r_key_len;
  logic              r_key_ovf;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic              w_enter_load;
  logic              w_enter_crypt;
  logic [KL_W-1:0]   w_len_eff;
  logic [PTR_W-1:0]  w_ptr_eff;
  logic              w_room;
  logic [DATA_W-1:0] w_key_word;
  logic [DATA_W-1:0] w_cipher;
  logic              w_ptr_last;
  logic [PTR_W-1:0]  w_ptr_next;
  logic              w_key_we;
  logic [PTR_W-1:0]  w_key_widx;
  logic [DATA_W-1:0] w_key_wdata;

  // Transition cycles see the cleared length/pointer so a word arriving on the
  // same edge already lands in slot 0 / uses key[0].
  always_comb begin
    w_enter_load  = kset && (r_state == ST_CRYPT);
    w_enter_crypt = !kset && (r_state == ST_LOAD);
    w_len_eff     = w_enter_load ? '0 : r_key_len;
    w_ptr_eff     = (w_enter_load || w_enter_crypt) ? '0 : r_ptr;
    w_room        = (w_len_eff < KL_MAX);
    w_key_word    = (r_key_len == '0) ? '0 : r_key[w_ptr_eff];
    w_cipher      = din ^ w_key_word;
    w_ptr_last    = (KL_W'(w_ptr_eff) == (r_key_len - KL_W'(1)));
    w_ptr_next    = ((r_key_len == '0) || w_ptr_last) ? '0 : (w_ptr_eff + PTR_W'(1));

    w_key_we    = 1'b0;
    w_key_widx  = w_ptr_eff;
    w_key_wdata = din;
    if (kset) begin
      if (din_valid && w_room) begin
        w_key_we   = 1'b1;
        w_key_widx = w_len_eff[PTR_W-1:0];
      end
    end else if (din_valid && mode && (r_key_len != '0)) begin
      // Feedback is always the ciphertext: computed on encrypt, received on decrypt.
      w_key_we    = 1'b1;
      w_key_wdata = decrypt ? din : w_cipher;
    end
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_KEY_LEN; i++) r_key[i] <= '0;
    end else if (w_key_we) begin
      r_key[w_key_widx] <= w_key_wdata;
    end
  end

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_CRYPT;
      r_ptr        <= '0;
      r_key_len    <= '0;
      r_key_ovf    <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state <= kset ? ST_LOAD : ST_CRYPT;
      if (kset) begin
        r_ptr        <= '0;
        r_dout_valid <= 1'b0;
        r_key_len    <= (din_valid && w_room) ? (w_len_eff + KL_W'(1)) : w_len_eff;
        if (din_valid && !w_room) r_key_ovf <= 1'b1;
        else if (w_enter_load)    r_key_ovf <= 1'b0;
      end else begin
        r_ptr        <= din_valid ? w_ptr_next : w_ptr_eff;
        r_dout_valid <= din_valid;
        if (din_valid) r_dout <= w_cipher;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign key_len    = r_key_len;
  assign key_full   = (r_key_len == KL_MAX);
  assign key_ovf    = r_key_ovf;

endmodule

// File: tb/tb_dea_stream_cipher.sv
// Table-driven bench with an output scoreboard for dea_stream_cipher
// (MAX_KEY_LEN = 8).
module tb_dea_stream_cipher;

  localparam int DW   = 8;
  localparam int MKL  = 8;
  localparam int KLW  = $clog2(MKL + 1);

  logic           dclk;
  logic           reset;
  logic           kset;
  logic           mode;
  logic           decrypt;
  logic           din_valid;
  logic [DW-1:0]  din;
  logic [DW-1:0]  dout;
  logic           dout_valid;
  logic [KLW-1:0] key_len;
  logic           key_full;
  logic           key_ovf;

  dea_stream_cipher #(.DATA_W(DW), .MAX_KEY_LEN(MKL)) dut (
    .dclk      (dclk),
    .reset     (reset),
    .kset      (kset),
    .mode      (mode),
    .decrypt   (decrypt),
    .din_valid (din_valid),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid),
    .key_len   (key_len),
    .key_full  (key_full),
    .key_ovf   (key_ovf)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  typedef struct {
    logic       ks;
    logic       md;
    logic       dc;
    logic       vl;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    int         kl;
    logic       ov;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  logic [7:0] last_dout;
  int         total;
  int         bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ks, input logic md, input logic dc, input logic vl,
                     input logic [7:0] d, input logic ev, input logic [7:0] ed,
                     input int kl, input logic ov);
    vec_t v;
    v.ks = ks; v.md = md; v.dc = dc; v.vl = vl; v.d = d;
    v.ev = ev; v.ed = ed; v.kl = kl; v.ov = ov;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] exp_d;
    kset      = v.ks;
    mode      = v.md;
    decrypt   = v.dc;
    din_valid = v.vl;
    din       = v.d;
    if (!v.ks && v.vl) sb_q.push_back(v.ed);
    @(posedge dclk);
    #1;
    chk({tag, "_vld"}, 32'(dout_valid), 32'(v.ev));
    if (dout_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_sb actual=%0h required=none", tag, dout);
      end else begin
        exp_d = sb_q.pop_front();
        chk({tag, "_dout"}, 32'(dout), 32'(exp_d));
        last_dout = exp_d;
      end
    end else begin
      chk({tag, "_hold"}, 32'(dout), 32'(last_dout));
    end
    chk({tag, "_klen"}, 32'(key_len), 32'(v.kl));
    chk({tag, "_full"}, 32'(key_full), 32'(v.kl == MKL));
    chk({tag, "_ovf"},  32'(key_ovf), 32'(v.ov));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t h;
    total = 0; bad = 0; last_dout = 8'h00;
    kset = 1'b0; mode = 1'b0; decrypt = 1'b0; din_valid = 1'b0; din = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 0);
    chk("rst_vld",  32'(dout_valid), 0);
    chk("rst_klen", 32'(key_len), 0);
    chk("rst_ovf",  32'(key_ovf), 0);
    chk("rst_full", 32'(key_full), 0);
    @(posedge dclk);
    @(posedge dclk);
    #1 reset = 1'b1;

    // empty key pass-through
    add(0,0,0,1,8'hA5, 1,8'hA5, 0,0);
    // basic repeating XOR "HELLO" with key "abc"
    add(1,0,0,1,8'h61, 0,8'h00, 1,0);
    add(1,0,0,1,8'h62, 0,8'h00, 2,0);
    add(1,0,0,1,8'h63, 0,8'h00, 3,0);
    add(0,0,0,1,8'h48, 1,8'h29, 3,0);
    add(0,0,0,1,8'h45, 1,8'h27, 3,0);
    add(0,0,0,1,8'h4C, 1,8'h2F, 3,0);
    add(0,0,0,1,8'h4C, 1,8'h2D, 3,0);
    add(0,0,0,1,8'h4F, 1,8'h2D, 3,0);
    // overflow: 10 words into 8 slots, then wrap-around encrypt
    for (int i = 1; i <= 10; i++) add(1,0,0,1,8'(i), 0,8'h00, (i < MKL) ? i : MKL, i > MKL);
    for (int i = 0; i < 9; i++)   add(0,0,0,1,8'h00, 1,8'((i % MKL) + 1), MKL, 1);
    // autokey encrypt then decrypt
    add(1,0,0,1,8'h61, 0,8'h00, 1,0);
    add(0,1,0,1,8'h48, 1,8'h29, 1,0);
    add(0,1,0,1,8'h45, 1,8'h6C, 1,0);
    add(1,0,0,1,8'h61, 0,8'h00, 1,0);
    add(0,1,1,1,8'h29, 1,8'h48, 1,0);
    add(0,1,1,1,8'h6C, 1,8'h45, 1,0);
    // gaps keep pointer and dout
    add(1,0,0,1,8'h10, 0,8'h00, 1,0);
    add(1,0,0,1,8'h20, 0,8'h00, 2,0);
    add(0,0,0,1,8'h00, 1,8'h10, 2,0);
    add(0,0,0,0,8'hFF, 0,8'h00, 2,0);
    add(0,0,0,0,8'hFF, 0,8'h00, 2,0);
    add(0,0,0,0,8'hFF, 0,8'h00, 2,0);
    add(0,0,0,1,8'h00, 1,8'h20, 2,0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // kset pulse without data clears the key -> pass-through
    h.ks = 1; h.md = 0; h.dc = 0; h.vl = 0; h.d = 8'h00; h.ev = 0; h.ed = 8'h00; h.kl = 0; h.ov = 0;
    run_vec(h, "tog_load");
    h.ks = 0; h.vl = 1; h.d = 8'h5A; h.ev = 1; h.ed = 8'h5A; h.kl = 0;
    run_vec(h, "tog_pass");

    // asynchronous reset mid-stream
    h.ks = 1; h.d = 8'h11; h.ev = 0; h.ed = 8'h00; h.kl = 1;
    run_vec(h, "rm_load");
    h.ks = 0; h.d = 8'h01; h.ev = 1; h.ed = 8'h10; h.kl = 1;
    run_vec(h, "rm_enc");
    din_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rm_dout", 32'(dout), 0);
    chk("rm_vld",  32'(dout_valid), 0);
    chk("rm_klen", 32'(key_len), 0);
    chk("rm_ovf",  32'(key_ovf), 0);
    #2 reset = 1'b1;
    last_dout = 8'h00;
    sb_q.delete();
    h.ks = 0; h.d = 8'h33; h.ev = 1; h.ed = 8'h33; h.kl = 0;
    run_vec(h, "rm_pass");
    din_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dea_stream_cipher.md
# dea_stream_cipher

Parametrised successor of the DEA XOR encryption block. It stores a variable-length key of up to MAX_KEY_LEN words and streams data through a registered XOR datapath. Compared with DEA it adds a valid handshake, key-length and overflow status, and a ciphertext-autokey mode with matching decrypt. It sits between the byte-stream host interface and the output file/UART path, in place of DEA.

## Interface

Parameters:
- DATA_W, 8, width of key words and data words
- MAX_KEY_LEN, 16, key storage depth in words; must be ≥1
- KL_W, $clog2(MAX_KEY_LEN+1), width of key_len (derived; do not override)

Ports:
- dclk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- kset  in  1  1 = key-load state, 0 = crypt state
- mode  in  1  0 = repeating-key XOR, 1 = ciphertext autokey
- decrypt  in  1  selects the autokey feedback source (see Operation); ignored when mode = 0
- din_valid  in  1  din is consumed on a rising edge where this is 1
- din  in  DATA_W  key word (kset = 1) or data word (kset = 0)
- dout  out  DATA_W  registered result
- dout_valid  out  1  1-cycle pulse marking a new dout
- key_len  out  KL_W  number of key words loaded
- key_full  out  1  key_len == MAX_KEY_LEN
- key_ovf  out  1  sticky; a key word was dropped because storage was full

## Operation

- States: LOAD (kset = 1) and CRYPT (kset = 0). The state register follows kset every cycle. Reset state is CRYPT.
- CRYPT→LOAD transition (first cycle with kset = 1):
  - key_len, ptr and key_ovf clear to 0.
  - A din_valid in that same cycle is stored as key[0].
- LOAD with din_valid:
  - If key_len < MAX_KEY_LEN: key[key_len] ← din, then key_len increments.
  - Otherwise the word is dropped and key_ovf ← 1.
  - dout_valid stays 0 in LOAD.
- LOAD→CRYPT transition: ptr ← 0.
- CRYPT with din_valid:
  - k = key[ptr], or 0 when key_len = 0 (pass-through).
  - dout ← din ^ k; dout_valid ← 1.
  - ptr ← (ptr == key_len−1) ? 0 : ptr+1. ptr stays 0 when key_len = 0.
- Autokey (mode = 1, key_len > 0): after use, key[ptr] ← din^k when decrypt = 0, or key[ptr] ← din when decrypt = 1. In both cases the feedback is the ciphertext, so the same key and mode with decrypt = 1 recovers the plaintext.
- Autokey overwrites key storage. A fresh key load is required before decrypting a stream.
- CRYPT with din_valid = 0: ptr, key and dout hold; dout_valid ← 0.
- mode and decrypt are sampled per word. Switching mid-stream takes effect on the next consumed word.
- key_full is combinational from key_len.

## Timing

- Reset (asynchronous, active-low), effective immediately with no clock required:
  - dout = 0, dout_valid = 0, key_len = 0, key_ovf = 0, ptr = 0, all key words = 0, state = CRYPT.
- Reset mid-stream discards the key and the pointer. Output after release is pass-through until a key is loaded.
- Latency: dout/dout_valid update on the same rising edge that consumes din, so data is visible 1 cycle after it is presented. Throughput is one word per cycle with no stalls.
- Key write and key_len increment happen on the same edge. The next word in the same LOAD burst goes to the next slot.
- Wrap-around: with key_len = N, word i of a CRYPT run uses key[i mod N]. A run starts after each LOAD→CRYPT transition. Pausing din_valid does not reset ptr.
- kset toggling with din_valid = 0 still clears key_len (CRYPT→LOAD) or ptr (LOAD→CRYPT).

## Test plan

- Basic repeating XOR: reset; load key 0x61,0x62,0x63; with mode = 0, send "HELLO" (0x48,0x45,0x4C,0x4C,0x4F). Expect dout 0x29,0x27,0x2F,0x2D,0x2D with key_len = 3.
- Overflow: MAX_KEY_LEN = 8; load 10 words 0x01..0x0A. Expect key_len = 8, key_full = 1, key_ovf = 1. Then encrypt nine 0x00 words and expect dout 0x01..0x08, 0x01.
- Autokey round trip:
  - Load key 0x61; with mode = 1, decrypt = 0, send 0x48,0x45. Expect 0x29,0x6C.
  - Reload 0x61; with decrypt = 1, send 0x29,0x6C. Expect 0x48,0x45.
- Empty key: after reset, with kset = 0, send 0xA5. Expect dout = 0xA5 with a dout_valid pulse.
- Gaps: key 0x10,0x20; send 0x00, idle 3 cycles, send 0x00. Expect 0x10 then 0x20. During the idle cycles dout holds 0x10 and dout_valid = 0.
- Reset mid-stream: drive reset low between edges during CRYPT. Expect dout, dout_valid and key_len at 0 before the next edge. After release, 0x33 in gives 0x33 out.
